fxp_sat_accumulator: RTL and testbench
======================================

Name: fxp_sat_accumulator

Overview:
- Sequential accumulate stage for the ODE datapath (e.g. Euler/RK sum terms).
- Consumes a stream of N-bit two's-complement fixed-point terms and adds or subtracts each into a running accumulator.
- Each step goes through one instance of the team's carry_select_adder (N even, multiple of 2).
- Uses the adder's overflow_flag and negative outputs to saturate each step, then returns the final sum over a valid/ready handshake.

Parameters:
- N, 16, data width in bits (two's complement, binary point irrelevant to this block; must be even).
- CNT_W, 8, width of the term-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- len  input  CNT_W  number of terms to accumulate; latched on start.
- init  input  N  initial accumulator value; latched on start.
- sub  input  1  0 = acc+term, 1 = acc-term; latched on start.
- in_data  input  N  term.
- in_valid  input  1  term valid.
- in_ready  output  1  block accepts a term this cycle.
- out_data  output  N  final accumulator value.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- sat_flag  output  1  sticky: at least one step saturated in current/last run.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc=0, count=0, sub_r=0.
  - in_ready=0, out_valid=0, out_data=0, sat_flag=0, busy=0.
  - Takes effect immediately, including mid-run; a partial run is discarded.
- Adder hookup: A=acc, B = sub_r ? ~in_data : in_data, cin=sub_r.
- Saturated next value:
  - overflow_flag=0 -> result.
  - overflow_flag=1 and negative=1 -> {1'b1,{N-1{1'b0}}} (most negative).
  - overflow_flag=1 and negative=0 -> {1'b0,{N-1{1'b1}}} (most positive).
  - Subtracting the most negative value is handled exactly by the adder flags; no special case.
- State IDLE: in_ready=0, out_valid=0, busy=0.
  - On start=1: acc<=init, count<=len, sub_r<=sub, sat_flag<=0.
  - If len==0, next state is DONE; otherwise ACCUM.
- State ACCUM: in_ready=1, busy=1.
  - Transfer occurs when in_valid & in_ready. On a transfer: acc<=saturated value; count<=count-1; sat_flag<=sat_flag|overflow_flag.
  - Transfer with count==1 -> DONE. No transfer -> hold everything.
  - Throughput is one term per cycle; in_valid gaps are allowed.
- State DONE: out_valid=1, out_data=acc, in_ready=0, busy=1.
  - out_valid and out_data are held stable until out_ready=1, then -> IDLE next cycle.
  - out_valid is asserted the cycle after the last accepted term, or the cycle after start when len==0.
- out_data: registered copy of acc, updated only on entry to DONE; holds its last value in IDLE.
- sat_flag: remains valid in IDLE until the next start.
- start outside IDLE is ignored. len/init/sub changes after start are ignored.
- start and out_ready handshake in the same cycle as DONE->IDLE: start is not seen until the IDLE cycle, so there is one bubble cycle minimum between runs.
- count wraps never: terms beyond len are not accepted (in_ready=0 in DONE).
- Maximum run length is 2^CNT_W-1 terms.

Test Plan:
- Basic add: init=0x0000, sub=0, len=3, terms 0x0001,0x0002,0x0003 back-to-back -> out_data=0x0006, sat_flag=0, out_valid 1 cycle after 3rd accept.
- Positive saturation: init=0x7000, len=2, terms 0x2000,0xF000 -> after step1 acc=0x7FFF (clamped), final 0x6FFF, sat_flag=1.
- Subtract/negative saturation: init=0x8100, sub=1, len=1, term 0x0200 -> 0x8000, sat_flag=1; a second run init=0x0000, sub=1, term 0x8000 -> 0x7FFF, sat_flag=1.
- len=0: start with init=0x1234 -> out_valid next cycle, out_data=0x1234, no terms accepted while in_valid=1.
- Handshake stress: random in_valid gaps; out_ready held low 5 cycles -> out_data/out_valid stable; start pulses during ACCUM/DONE ignored; result matches a saturating reference model.
- Reset mid-run: rst_n low after 2 of 5 terms -> all outputs 0 immediately; a new run (init=0x0010, len=1, term 0x0001) -> 0x0011.

Source files
------------

// File: rtl/fxp_sat_accumulator.sv
// Saturating fixed-point accumulate stage: folds a stream of two's-complement terms
// into a running sum through a carry-select adder and returns the result over valid/ready.

module carry_select_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         overflow_flag,
    output logic         negative
);
    localparam int NB = N / 2;

    logic [NB:0] carry;
    logic        msb_carry_in;

    assign carry[0] = cin;

    // Each 2-bit block precomputes both carry-in cases; the incoming carry picks one.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_blk
            logic [2:0] res_c0;
            logic [2:0] res_c1;

            assign res_c0 = {1'b0, a[2*gi+1:2*gi]} + {1'b0, b[2*gi+1:2*gi]};
            assign res_c1 = {1'b0, a[2*gi+1:2*gi]} + {1'b0, b[2*gi+1:2*gi]} + 3'd1;

            assign sum[2*gi+1:2*gi] = carry[gi] ? res_c1[1:0] : res_c0[1:0];
            assign carry[gi+1]      = carry[gi] ? res_c1[2]   : res_c0[2];
        end
    endgenerate

    // Overflow when the carry into the sign bit differs from the carry out of it.
    assign msb_carry_in  = a[N-1] ^ b[N-1] ^ sum[N-1];
    assign overflow_flag = msb_carry_in ^ carry[NB];
    // Sign of the exact (unbounded) result, which tells which rail to clamp to.
    assign negative      = sum[N-1] ^ overflow_flag;
endmodule

module fxp_sat_accumulator #(
    parameter int N     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [N-1:0]     init,
    input  logic             sub,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat_flag,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MOST_POS = {1'b0, {(N-1){1'b1}}};

    state_t           state_reg, state_next;
    logic [N-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             sub_reg, sub_next;
    logic             sat_reg, sat_next;
    logic [N-1:0]     out_data_reg, out_data_next;

    logic [N-1:0]     add_b;
    logic [N-1:0]     add_sum;
    logic             add_ovf;
    logic             add_neg;
    logic [N-1:0]     sat_value;
    logic             transfer;

    // Subtraction as acc + ~term + 1, so the adder flags stay exact for every operand.
    assign add_b = sub_reg ? ~in_data : in_data;

    carry_select_adder #(
        .N (N)
    ) u_adder (
        .a             (acc_reg),
        .b             (add_b),
        .cin           (sub_reg),
        .sum           (add_sum),
        .overflow_flag (add_ovf),
        .negative      (add_neg)
    );

    assign sat_value = !add_ovf ? add_sum : (add_neg ? MOST_NEG : MOST_POS);
    assign transfer  = (state_reg == ACCUM) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            count_reg    <= '0;
            sub_reg      <= 1'b0;
            sat_reg      <= 1'b0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            count_reg    <= count_next;
            sub_reg      <= sub_next;
            sat_reg      <= sat_next;
            out_data_reg <= out_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        count_next    = count_reg;
        sub_next      = sub_reg;
        sat_next      = sat_reg;
        out_data_next = out_data_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    acc_next   = init;
                    count_next = len;
                    sub_next   = sub;
                    sat_next   = 1'b0;
                    if (len == '0) begin
                        state_next    = DONE;
                        out_data_next = init;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (transfer) begin
                    acc_next   = sat_value;
                    count_next = count_reg - 1'b1;
                    sat_next   = sat_reg | add_ovf;
                    if (count_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_next    = DONE;
                        out_data_next = sat_value;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == ACCUM) || (state_reg == DONE);
    assign out_data  = out_data_reg;
    assign sat_flag  = sat_reg;
endmodule

// File: tb/tb_fxp_sat_accumulator.sv
// Directed bench for fxp_sat_accumulator: hand-computed runs covering add, both
// saturation rails, zero-length runs, handshake holds, ignored starts and reset mid-run.

module tb_fxp_sat_accumulator;
    localparam int N     = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [N-1:0]     init;
    logic             sub;
    logic [N-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sat_flag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    fxp_sat_accumulator #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .init      (init),
        .sub       (sub),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Saturating reference step: returns {overflow, value}.
    function automatic logic [16:0] sat_step(input logic [15:0] a, input logic [15:0] b,
                                             input logic s);
        int r;
        logic [31:0] rv;
        r = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        if (r > 32767) return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        rv = r;
        return {1'b0, rv[15:0]};
    endfunction

    task automatic start_run(input logic [15:0] i_init, input logic [7:0] i_len, input logic i_sub);
        @(negedge clk);
        start = 1'b1;
        init  = i_init;
        len   = i_len;
        sub   = i_sub;
        @(posedge clk);
        #1;
        start = 1'b0;
        init  = 16'hDEAD;
        len   = 8'h07;
        sub   = ~i_sub;
    endtask

    task automatic send_term(input logic [15:0] d, input string tag);
        int k;
        k = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k == 50) check({tag, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_run(input logic [15:0] exp, input logic exp_sat, input int hold,
                              input string tag);
        int k;
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_out_data"}, {16'd0, out_data}, {16'd0, exp});
        check({tag, "_sat_flag"}, {31'd0, sat_flag}, {31'd0, exp_sat});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_data !== exp)
                check({tag, "_hold"}, {15'd0, out_valid, out_data}, {15'd0, 1'b1, exp});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_data"}, {16'd0, out_data}, {16'd0, exp});
    endtask

    logic [15:0] stress_terms [6] = '{16'h7000, 16'h8000, 16'h0001, 16'hFFFF, 16'h4000, 16'h9000};
    logic [15:0] acc_m;
    logic        sat_m;
    logic [16:0] step_m;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        init      = '0;
        sub       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, back-to-back terms.
        start_run(16'h0000, 8'd3, 1'b0);
        check("add_in_ready", {31'd0, in_ready}, 32'd1);
        check("add_busy", {31'd0, busy}, 32'd1);
        send_term(16'h0001, "add_t0");
        send_term(16'h0002, "add_t1");
        send_term(16'h0003, "add_t2");
        check("add_valid_latency", {31'd0, out_valid}, 32'd1);
        finish_run(16'h0006, 1'b0, 0, "add");

        // Positive rail: 0x7000+0x2000 clamps to 0x7FFF, then +0xF000 -> 0x6FFF.
        start_run(16'h7000, 8'd2, 1'b0);
        send_term(16'h2000, "pos_t0");
        send_term(16'hF000, "pos_t1");
        finish_run(16'h6FFF, 1'b1, 0, "pos");

        // Negative rail via subtraction, then subtracting the most negative value.
        start_run(16'h8100, 8'd1, 1'b1);
        send_term(16'h0200, "neg_t0");
        finish_run(16'h8000, 1'b1, 0, "neg");
        start_run(16'h0000, 8'd1, 1'b1);
        send_term(16'h8000, "submin_t0");
        finish_run(16'h7FFF, 1'b1, 0, "submin");

        // Zero-length run: result next cycle, terms refused, start ignored in DONE.
        start_run(16'h1234, 8'd0, 1'b0);
        check("len0_valid_latency", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        in_data  = 16'h5555;
        start    = 1'b1;
        init     = 16'h0000;
        len      = 8'd4;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("len0_in_ready", {31'd0, in_ready}, 32'd0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        finish_run(16'h1234, 1'b0, 5, "len0");

        // Add run with gaps, a start pulse mid-run and a held output.
        start_run(16'h4000, 8'd5, 1'b0);
        send_term(16'h3000, "gap_t0");
        repeat (2) @(posedge clk);
        #1;
        send_term(16'h2000, "gap_t1");
        start = 1'b1;
        init  = 16'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("gap_busy", {31'd0, busy}, 32'd1);
        send_term(16'h8000, "gap_t2");
        send_term(16'h0005, "gap_t3");
        @(posedge clk);
        #1;
        send_term(16'hFFF0, "gap_t4");
        finish_run(16'hFFF4, 1'b1, 5, "gap");

        // Subtract run with gaps against the reference model.
        acc_m = 16'h1000;
        sat_m = 1'b0;
        foreach (stress_terms[i]) begin
            step_m = sat_step(acc_m, stress_terms[i], 1'b1);
            acc_m  = step_m[15:0];
            sat_m  = sat_m | step_m[16];
        end
        start_run(16'h1000, 8'd6, 1'b1);
        foreach (stress_terms[i]) begin
            send_term(stress_terms[i], "model_t");
            repeat (i % 3) @(posedge clk);
            #1;
        end
        finish_run(acc_m, sat_m, 5, "model");

        // Reset in the middle of a run discards it.
        start_run(16'h0100, 8'd5, 1'b0);
        send_term(16'h0001, "rst_t0");
        send_term(16'h0002, "rst_t1");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", {16'd0, out_data}, 32'd0);
        check("midrst_sat_flag", {31'd0, sat_flag}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run(16'h0010, 8'd1, 1'b0);
        send_term(16'h0001, "post_t0");
        finish_run(16'h0011, 1'b0, 0, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
